// File: rtl/fp_add_issue.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_issue
// Brief    : Issue/result-collection controller for fp_add. Holds operands
//            stable for LAT cycles and queues results in a small FIFO.
//            Optional macro: FP_ADD_ISSUE_STICKY_EN (sticky exception flags).
// Revision : 1.0  initial release
// ============================================================================
module fp_add_issue #(
  parameter int W     = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [2:0]   req_rm,
  output logic [W-1:0] add_in1,
  output logic [W-1:0] add_in2,
  output logic [2:0]   add_round_m,
  output logic         add_act,
  input  logic [W-1:0] add_out,
  input  logic         add_ov,
  input  logic         add_un,
  input  logic         add_inv,
  input  logic         add_inexact,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [3:0]   rsp_flags
`ifdef FP_ADD_ISSUE_STICKY_EN
  ,
  input  logic         flags_clr,
  output logic [3:0]   sticky_flags
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_HW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [LAT:0]      r_vpipe;
  logic [c_HW-1:0]   r_hold_cnt;
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_CW-1:0]   r_count;
  logic [W-1:0]      r_mem_data  [DEPTH];
  logic [3:0]        r_mem_flags [DEPTH];

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_push_flags;
  logic [c_CW:0]     w_inflight;
  logic [c_CW:0]     w_used;

  // Every op still in the adder pipe holds a FIFO slot reserved for its result.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= LAT; i++) begin
      w_inflight = w_inflight + (c_CW+1)'(r_vpipe[i]);
    end
  end

  assign w_used       = {1'b0, r_count} + w_inflight;
  assign req_ready    = !rst && (r_hold_cnt == '0) && (w_used < (c_CW+1)'(DEPTH));
  assign w_accept     = req_valid && req_ready;
  assign w_push       = r_vpipe[LAT];
  assign w_push_flags = {add_inv, add_ov, add_un, add_inexact};
  assign add_act      = |r_vpipe[LAT-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe     <= '0;
      r_hold_cnt  <= '0;
      add_in1     <= '0;
      add_in2     <= '0;
      add_round_m <= '0;
    end else begin
      r_vpipe <= {r_vpipe[LAT-1:0], w_accept};
      if (w_accept) begin
        add_in1     <= req_a;
        add_in2     <= req_b;
        add_round_m <= req_rm;
        r_hold_cnt  <= c_HW'(LAT - 1);
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - c_HW'(1);
      end
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr]  <= add_out;
      r_mem_flags[r_wptr] <= w_push_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? r_mem_data[r_rptr]  : '0;
  assign rsp_flags = rsp_valid ? r_mem_flags[r_rptr] : '0;

`ifdef FP_ADD_ISSUE_STICKY_EN
  // A clear coinciding with a push keeps only the pushed flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (flags_clr) begin
      sticky_flags <= w_push ? w_push_flags : 4'b0000;
    end else if (w_push) begin
      sticky_flags <= sticky_flags | w_push_flags;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_add_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_issue
// Brief    : Directed self-checking bench for fp_add_issue with a behavioural
//            two-stage fp_add stand-in driven from the vector table.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_issue;

  localparam int W     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int NV    = 11;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [2:0]   req_rm = '0;
  logic [W-1:0] add_in1;
  logic [W-1:0] add_in2;
  logic [2:0]   add_round_m;
  logic         add_act;
  logic [W-1:0] add_out;
  logic         add_ov;
  logic         add_un;
  logic         add_inv;
  logic         add_inexact;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;
`ifdef FP_ADD_ISSUE_STICKY_EN
  logic         flags_clr = 1'b0;
  logic [3:0]   sticky_flags;
`endif

  vec_t vt [NV];
  vec_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  int   cyc   = 0;

  fp_add_issue #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rm      (req_rm),
    .add_in1     (add_in1),
    .add_in2     (add_in2),
    .add_round_m (add_round_m),
    .add_act     (add_act),
    .add_out     (add_out),
    .add_ov      (add_ov),
    .add_un      (add_un),
    .add_inv     (add_inv),
    .add_inexact (add_inexact),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags)
`ifdef FP_ADD_ISSUE_STICKY_EN
    ,
    .flags_clr   (flags_clr),
    .sticky_flags(sticky_flags)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] lookup(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] rm);
    lookup = {32'hBAD0_0BAD, 4'hF};
    for (int i = 0; i < NV; i++) begin
      if (vt[i].a == a && vt[i].b == b && vt[i].rm == rm) lookup = {vt[i].r, vt[i].f};
    end
  endfunction

  // Adder stand-in: result lands LAT=2 cycles after the operands, and is
  // poisoned if the operands did not stay constant over both stages.
  logic [35:0] stub_st1;
  logic [66:0] stub_prev;
  always @(posedge clk) begin
    stub_st1  <= lookup(add_in1, add_in2, add_round_m);
    stub_prev <= {add_in1, add_in2, add_round_m};
    if (stub_prev == {add_in1, add_in2, add_round_m})
      {add_out, add_inv, add_ov, add_un, add_inexact} <= stub_st1;
    else
      {add_out, add_inv, add_ov, add_un, add_inexact} <= {32'hBAD0_0BAD, 4'hF};
  end

  // Response scoreboard and FIFO-overflow monitor.
  always begin
    vec_t e;
    logic ovf;
    @(negedge clk);
    #1;
    if (!rst) begin
      ovf = (int'(dut.r_count) == DEPTH) && dut.r_vpipe[LAT];
      check("fifo_ovf", ovf, 1'b0);
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.r);
          check("rsp_flags", rsp_flags, e.f);
        end
      end
    end
  end

  // Offer vector idx for up to max_wait cycles; on accept return in cycle c0.
  task automatic issue(input int idx, input int max_wait, output logic ok, output int acc_cyc);
    ok      = 1'b0;
    acc_cyc = 0;
    req_valid = 1'b1;
    req_a     = vt[idx].a;
    req_b     = vt[idx].b;
    req_rm    = vt[idx].rm;
    for (int t = 0; t <= max_wait; t++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      sb.push_back(vt[idx]);
      @(negedge clk);
      acc_cyc = cyc;
      check("c0_in1", add_in1, vt[idx].a);
      check("c0_in2", add_in2, vt[idx].b);
      check("c0_rm", add_round_m, vt[idx].rm);
      check("c0_act", add_act, 1'b1);
      check("c0_hold_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   ac;
    int   prev_ac;
    int   base;
    int   k;
    logic seen;

    vt[0]  = '{32'h3F800000, 32'h3F800000, 3'd0, 32'h40000000, 4'b0000};
    vt[1]  = '{32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 4'b1000};
    vt[2]  = '{32'h3F800000, 32'h33800000, 3'd0, 32'h3F800000, 4'b0001};
    vt[3]  = '{32'h40000000, 32'h40000000, 3'd1, 32'h40800000, 4'b0000};
    vt[4]  = '{32'h3F800000, 32'h40000000, 3'd2, 32'h40400000, 4'b0000};
    vt[5]  = '{32'h3F000000, 32'h3F000000, 3'd3, 32'h3F800000, 4'b0000};
    vt[6]  = '{32'h40400000, 32'h3F800000, 3'd4, 32'h40800000, 4'b0000};
    vt[7]  = '{32'h40800000, 32'h40800000, 3'd0, 32'h41000000, 4'b0000};
    vt[8]  = '{32'h3F800000, 32'hBF800000, 3'd1, 32'h00000000, 4'b0000};
    vt[9]  = '{32'h40000000, 32'hBF800000, 3'd2, 32'h3F800000, 4'b0000};
    vt[10] = '{32'h3F800000, 32'h3F000000, 3'd3, 32'h3FC00000, 4'b0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_act", add_act, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_in1", add_in1, 32'h0);
    check("post_rst_in2", add_in2, 32'h0);
    check("post_rst_rm", add_round_m, 3'd0);
    check("post_rst_data", rsp_data, 32'h0);
    check("post_rst_flags", rsp_flags, 4'h0);
`ifdef FP_ADD_ISSUE_STICKY_EN
    check("post_rst_sticky", sticky_flags, 4'h0);
`endif

    // 1.0 + 1.0 and accept-to-valid latency
    rsp_ready = 1'b1;
    issue(0, 10, ok, ac);
    check("t1_accept", ok, 1'b1);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t1_latency", k, LAT + 1);
    wait_drain();

    // +inf + -inf -> qNaN, invalid
    issue(1, 10, ok, ac);
    check("t2_accept", ok, 1'b1);
    wait_drain();

    // Continuous stream: one accept every LAT cycles, in-order results
    base = n_rsp;
    prev_ac = 0;
    for (int i = 3; i <= 10; i++) begin
      issue(i, 20, ok, ac);
      check("t3_accept", ok, 1'b1);
      if (i > 3) check("t3_spacing", ac - prev_ac, LAT);
      prev_ac = ac;
      @(negedge clk);
      check("t3_hold_in1", add_in1, vt[i].a);
      check("t3_hold_rm", add_round_m, vt[i].rm);
      check("t3_ready_back", req_ready, 1'b1);
    end
    wait_drain();
    check("t3_count", n_rsp - base, 8);

    // Backpressure: FIFO of 4 fills, fifth stalls, drains in order
    base = n_rsp;
    rsp_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      issue(3 + j, 20, ok, ac);
      check("t4_fill_accept", ok, 1'b1);
    end
    issue(7, 12, ok, ac);
    check("t4_stall", ok, 1'b0);
    check("t4_stall_ready", req_ready, 1'b0);
    check("t4_valid_full", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    issue(7, 20, ok, ac);
    check("t4_resume5", ok, 1'b1);
    issue(8, 20, ok, ac);
    check("t4_resume6", ok, 1'b1);
    wait_drain();
    check("t4_count", n_rsp - base, 6);

    // Reset the cycle after an accept discards the in-flight op
    base = n_rsp;
    issue(1, 10, ok, ac);
    check("t5_accept", ok, 1'b1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("t5_rst_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", rsp_valid, 1'b0);
    check("t5_act", add_act, 1'b0);
    check("t5_in1", add_in1, 32'h0);
    check("t5_data", rsp_data, 32'h0);
    check("t5_ready", req_ready, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("t5_no_rsp", seen, 1'b0);
    check("t5_none_popped", n_rsp - base, 0);
    issue(0, 10, ok, ac);
    check("t5_post_accept", ok, 1'b1);
    wait_drain();
    check("t5_post_count", n_rsp - base, 1);

`ifdef FP_ADD_ISSUE_STICKY_EN
    // Sticky inexact, then clear coinciding with an exact push
    issue(2, 10, ok, ac);
    wait_drain();
    check("sticky_inexact", sticky_flags, 4'b0001);
    issue(0, 10, ok, ac);
    @(negedge clk);
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("sticky_clr_push", sticky_flags, 4'b0000);
    wait_drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
